// File: rtl/calc_ctrl_seq.sv
// Keypad-calculator controller: builds decimal operands, sequences add/sub and register-file store/load.
// Optional macro CALC_ERR_EN enables the sticky err flag for out-of-range addresses and digit overflow.
module calc_ctrl_seq #(
  parameter int WIDTH  = 8,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        key,
  input  logic [WIDTH-1:0]  sum_in,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  acc_a,
  output logic [WIDTH-1:0]  acc_b,
  output logic              cin,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_we,
  output logic [WIDTH-1:0]  reg_wdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EXEC      = 3'd1,
    LOAD_ADDR = 3'd2,
    LOAD_DATA = 3'd3,
    STORE     = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_STORE = 4'd12;
  localparam logic [3:0] KEY_LOAD  = 4'd13;
  localparam logic [3:0] KEY_ENTER = 4'd14;
  localparam logic [3:0] KEY_CLEAR = 4'd15;

  localparam logic [WIDTH:0] NREG_V = (WIDTH+1)'(NREG);

  state_t state, state_n;
  logic [WIDTH-1:0]  acc_a_n, acc_b_n, reg_wdata_n;
  logic [ADDR_W-1:0] reg_addr_n;
  logic              cin_n, reg_we_n, busy_n;
  logic [WIDTH-1:0]  digit_val;
  logic              addr_ok;

  assign addr_ok = ({1'b0, acc_b} < NREG_V);

`ifdef CALC_ERR_EN
  // Wide product keeps the carry-out bits so overflow can be flagged.
  logic [WIDTH+3:0] digit_full;
  logic             digit_ovf;
  logic             err_n;

  assign digit_full = {4'b0, acc_b} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, key};
  assign digit_val  = digit_full[WIDTH-1:0];
  assign digit_ovf  = |digit_full[WIDTH+3:WIDTH];
`else
  assign digit_val = acc_b * WIDTH'(10) + WIDTH'(key);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc_a     <= '0;
      acc_b     <= '0;
      cin       <= 1'b0;
      reg_addr  <= '0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      acc_a     <= acc_a_n;
      acc_b     <= acc_b_n;
      cin       <= cin_n;
      reg_addr  <= reg_addr_n;
      reg_we    <= reg_we_n;
      reg_wdata <= reg_wdata_n;
      busy      <= busy_n;
    end
  end

`ifdef CALC_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= err_n;
  end
`else
  assign err = 1'b0;
`endif

  // reg_we is raised on the accepting edge so it is high exactly while in STORE.
  always_comb begin
    state_n     = state;
    acc_a_n     = acc_a;
    acc_b_n     = acc_b;
    cin_n       = cin;
    reg_addr_n  = reg_addr;
    reg_we_n    = 1'b0;
    reg_wdata_n = reg_wdata;
`ifdef CALC_ERR_EN
    err_n       = err;
`endif
    unique case (state)
      IDLE: begin
        if (key_valid) begin
          if (key <= 4'd9) begin
            acc_b_n = digit_val;
`ifdef CALC_ERR_EN
            if (digit_ovf) err_n = 1'b1;
`endif
          end else begin
            case (key)
              KEY_ADD: begin
                cin_n   = 1'b0;
                state_n = EXEC;
              end
              KEY_SUB: begin
                cin_n   = 1'b1;
                state_n = EXEC;
              end
              KEY_STORE: begin
                if (addr_ok) begin
                  reg_addr_n  = acc_b[ADDR_W-1:0];
                  reg_wdata_n = acc_a;
                  reg_we_n    = 1'b1;
                  state_n     = STORE;
                end
`ifdef CALC_ERR_EN
                else err_n = 1'b1;
`endif
              end
              KEY_LOAD: begin
                if (addr_ok) begin
                  reg_addr_n = acc_b[ADDR_W-1:0];
                  state_n    = LOAD_ADDR;
                end
`ifdef CALC_ERR_EN
                else err_n = 1'b1;
`endif
              end
              KEY_ENTER: begin
                acc_a_n = acc_b;
                acc_b_n = '0;
              end
              KEY_CLEAR: begin
                acc_a_n = '0;
                acc_b_n = '0;
                cin_n   = 1'b0;
`ifdef CALC_ERR_EN
                err_n   = 1'b0;
`endif
              end
              default: ;
            endcase
          end
        end
      end
      EXEC: begin
        acc_b_n = sum_in;
        acc_a_n = '0;
        state_n = IDLE;
      end
      LOAD_ADDR: state_n = LOAD_DATA;
      LOAD_DATA: begin
        acc_b_n = rd_data;
        state_n = IDLE;
      end
      STORE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_calc_ctrl_seq.sv
// Directed testbench for calc_ctrl_seq with a behavioural adder and register file.
module tb_calc_ctrl_seq;

  localparam int WIDTH  = 8;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;
`ifdef CALC_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              key_valid;
  logic [3:0]        key;
  logic [WIDTH-1:0]  sum_in;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  acc_a, acc_b, reg_wdata;
  logic              cin, reg_we, busy, err;
  logic [ADDR_W-1:0] reg_addr;
  logic [WIDTH-1:0]  mem [NREG];

  int n_checks = 0;
  int n_fail   = 0;

  calc_ctrl_seq #(.WIDTH(WIDTH), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key(key),
    .sum_in(sum_in), .rd_data(rd_data), .acc_a(acc_a), .acc_b(acc_b),
    .cin(cin), .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // External datapath: combinational adder and synchronous-read register file.
  assign sum_in = acc_a + (cin ? ~acc_b : acc_b) + WIDTH'(cin);

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (reg_we) mem[reg_addr] <= reg_wdata;
      rd_data <= mem[reg_addr];
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key       = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; key_valid = 1'b0; key = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({acc_a, acc_b, reg_wdata, reg_addr, cin, reg_we, busy, err} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got a=%0d b=%0d wd=%0d addr=%0d cin=%0d we=%0d busy=%0d err=%0d expected all 0",
               acc_a, acc_b, reg_wdata, reg_addr, cin, reg_we, busy, err);
    end
  endtask

  task automatic test_digits;
    press(4'd1);
    press(4'd2);
    n_checks++;
    if (acc_b !== 8'd12) begin n_fail++; $display("[TB] FAIL digits_12: got %0d expected 12", acc_b); end
    press(4'd3);
    n_checks++;
    if (acc_b !== 8'd123) begin n_fail++; $display("[TB] FAIL digits_123: got %0d expected 123", acc_b); end
    n_checks++;
    if (acc_a !== 8'd0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL digits_a_busy: got a=%0d busy=%0d expected a=0 busy=0", acc_a, busy);
    end
  endtask

  task automatic test_add;
    press(4'd15);
    press(4'd4); press(4'd5); press(4'd14);
    n_checks++;
    if (acc_a !== 8'd45 || acc_b !== 8'd0) begin
      n_fail++; $display("[TB] FAIL enter: got a=%0d b=%0d expected a=45 b=0", acc_a, acc_b);
    end
    press(4'd1); press(4'd7); press(4'd10);
    n_checks++;
    if (busy !== 1'b1 || acc_b !== 8'd17) begin
      n_fail++; $display("[TB] FAIL add_exec: got busy=%0d b=%0d expected busy=1 b=17", busy, acc_b);
    end
    @(negedge clk);
    n_checks++;
    if (acc_b !== 8'd62 || acc_a !== 8'd0 || cin !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL add_result: got b=%0d a=%0d cin=%0d busy=%0d expected b=62 a=0 cin=0 busy=0",
                         acc_b, acc_a, cin, busy);
    end
  endtask

  task automatic test_sub;
    press(4'd15);
    press(4'd5); press(4'd14); press(4'd7); press(4'd11);
    @(negedge clk);
    n_checks++;
    if (acc_b !== 8'd254 || cin !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sub_wrap: got b=%0d cin=%0d expected b=254 cin=1", acc_b, cin);
    end
    press(4'd14);
    n_checks++;
    if (cin !== 1'b1 || acc_a !== 8'd254) begin
      n_fail++; $display("[TB] FAIL sub_cin_hold: got cin=%0d a=%0d expected cin=1 a=254", cin, acc_a);
    end
  endtask

  task automatic test_store;
    press(4'd15);
    press(4'd9); press(4'd14); press(4'd3); press(4'd12);
    n_checks++;
    if (reg_we !== 1'b1 || reg_addr !== 4'd3 || reg_wdata !== 8'd9 || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL store_pulse: got we=%0d addr=%0d wd=%0d busy=%0d expected we=1 addr=3 wd=9 busy=1",
                         reg_we, reg_addr, reg_wdata, busy);
    end
    @(negedge clk);
    n_checks++;
    if (reg_we !== 1'b0 || busy !== 1'b0 || acc_a !== 8'd9 || acc_b !== 8'd3) begin
      n_fail++; $display("[TB] FAIL store_done: got we=%0d busy=%0d a=%0d b=%0d expected we=0 busy=0 a=9 b=3",
                         reg_we, busy, acc_a, acc_b);
    end
  endtask

  task automatic test_load;
    press(4'd15);
    press(4'd3); press(4'd13);
    @(negedge clk);
    n_checks++;
    if (acc_b !== 8'd3 || busy !== 1'b1 || reg_addr !== 4'd3) begin
      n_fail++; $display("[TB] FAIL load_wait: got b=%0d busy=%0d addr=%0d expected b=3 busy=1 addr=3", acc_b, busy, reg_addr);
    end
    @(negedge clk);
    n_checks++;
    if (acc_b !== 8'd9 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL load_data: got b=%0d busy=%0d expected b=9 busy=0", acc_b, busy);
    end
  endtask

  task automatic test_key_while_busy;
    press(4'd15);
    press(4'd4); press(4'd14); press(4'd5); press(4'd10);
    key_valid = 1'b1;
    key       = 4'd8;
    @(negedge clk);
    key_valid = 1'b0;
    n_checks++;
    if (acc_b !== 8'd9 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL busy_drop: got b=%0d busy=%0d expected b=9 busy=0", acc_b, busy);
    end
    @(negedge clk);
    n_checks++;
    if (acc_b !== 8'd9) begin n_fail++; $display("[TB] FAIL busy_drop_hold: got %0d expected 9", acc_b); end
  endtask

  task automatic test_overflow_range;
    press(4'd15);
    press(4'd2); press(4'd6); press(4'd0);
    n_checks++;
    if (acc_b !== 8'd4 || err !== ERR_ON) begin
      n_fail++; $display("[TB] FAIL overflow: got b=%0d err=%0d expected b=4 err=%0d", acc_b, err, ERR_ON);
    end
    press(4'd15);
    press(4'd2); press(4'd0); press(4'd12);
    n_checks++;
    if (reg_we !== 1'b0 || busy !== 1'b0 || acc_b !== 8'd20 || err !== ERR_ON) begin
      n_fail++; $display("[TB] FAIL store_oor: got we=%0d busy=%0d b=%0d err=%0d expected we=0 busy=0 b=20 err=%0d",
                         reg_we, busy, acc_b, err, ERR_ON);
    end
    press(4'd13);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || acc_b !== 8'd20 || err !== ERR_ON) begin
      n_fail++; $display("[TB] FAIL load_oor: got busy=%0d b=%0d err=%0d expected busy=0 b=20 err=%0d",
                         busy, acc_b, err, ERR_ON);
    end
    press(4'd15);
    n_checks++;
    if (err !== 1'b0 || acc_b !== 8'd0) begin
      n_fail++; $display("[TB] FAIL clear_err: got err=%0d b=%0d expected err=0 b=0", err, acc_b);
    end
  endtask

  task automatic test_reset_midload;
    press(4'd15);
    press(4'd3); press(4'd13);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({acc_a, acc_b, reg_wdata, reg_addr, cin, reg_we, busy, err} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_midload: got a=%0d b=%0d addr=%0d busy=%0d expected all 0",
                         acc_a, acc_b, reg_addr, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (acc_b !== 8'd0 || busy !== 1'b0 || reg_we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL after_reset: got b=%0d busy=%0d we=%0d expected 0 0 0", acc_b, busy, reg_we);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_add();
    test_sub();
    test_store();
    test_load();
    test_key_while_busy();
    test_overflow_range();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_ctrl_seq.md
Name: calc_ctrl_seq

Overview:
Clocked, parametrised keypad-calculator controller. It accepts one key code per valid strobe and builds multi-digit decimal operands. It drives an external combinational add/sub unit and sequences store/load transfers to a synchronous-read register file. It sits between the keypad decoder and the datapath (adder + register file).

Parameters:
WIDTH, 8, operand/accumulator width in bits
NREG, 16, number of register-file entries
ADDR_W, 4, register address width; NREG must be <= 2**ADDR_W

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all state and outputs
key_valid  input  1  one-cycle strobe; key is sampled when high
key  input  4  key code: 0-9 digit, 10 add, 11 sub, 12 store, 13 load, 14 enter, 15 clear
sum_in  input  WIDTH  external adder result; sum_in = acc_a + (cin ? ~acc_b : acc_b) + cin
rd_data  input  WIDTH  register-file read data, valid one cycle after reg_addr is registered
acc_a  output  WIDTH  operand A register
acc_b  output  WIDTH  operand B / entry / display register
cin  output  1  0 = add, 1 = subtract
reg_addr  output  ADDR_W  register-file address (registered)
reg_we  output  1  register-file write enable, one-cycle pulse
reg_wdata  output  WIDTH  register-file write data (registered)
busy  output  1  high when state != IDLE; keys are dropped while high
err  output  1  sticky error flag; cleared by key 15 or reset

Behaviour:
- Reset value of every output and internal register is 0. The state machine returns to IDLE, including when reset is asserted mid-operation; reg_we is never high in the cycle after reset.
- States: IDLE, EXEC, LOAD_ADDR, LOAD_DATA, STORE. All outputs are registered.
- Key acceptance: a key is accepted only when key_valid=1 and the state is IDLE. A key with key_valid=1 while busy=1 is discarded with no side effect.
- Digit d (0-9):
  - acc_b <= (acc_b*10 + d) mod 2**WIDTH.
  - Stays in IDLE; single cycle.
- Enter (14): acc_a <= acc_b; acc_b <= 0. Single cycle.
- Add (10) / Sub (11):
  - On the accepting edge, cin <= 0 (add) or 1 (sub), and state goes to EXEC.
  - In EXEC, on the next edge: acc_b <= sum_in, acc_a <= 0, state goes to IDLE.
  - Result is visible 2 edges after acceptance.
  - Subtraction wraps modulo 2**WIDTH; cin holds its last value after the operation.
- Store (12):
  - If acc_b < NREG: reg_addr <= acc_b[ADDR_W-1:0], reg_wdata <= acc_a, state goes to STORE.
  - In STORE: reg_we=1 for exactly one cycle, then IDLE. acc_a and acc_b are unchanged.
- Load (13):
  - If acc_b < NREG: reg_addr <= acc_b[ADDR_W-1:0], state goes to LOAD_ADDR, then LOAD_DATA.
  - On the LOAD_DATA edge: acc_b <= rd_data, state goes to IDLE. acc_b updates 3 edges after acceptance.
- Address out of range: store/load with acc_b >= NREG performs no transfer and stays in IDLE. err is set only if CALC_ERR_EN is defined.
- Clear (15): acc_a, acc_b, cin, err <= 0. Single cycle.

Optional Feature:
Macro CALC_ERR_EN.
- Defined:
  - err sets on an out-of-range store/load address.
  - err also sets on digit-entry overflow, i.e. acc_b*10 + d > 2**WIDTH-1. The truncated value is still written.
  - err is sticky until clear or reset.
- Undefined: err is constant 0 and no range/overflow logic is synthesised. Out-of-range store/load is still a silent no-op.

Test Plan:
- Keys 1,2,3 (WIDTH=8) -> acc_b=123 after 3 accepted strobes; acc_a=0; busy stays 0.
- Keys 4,5,enter,1,7,add, with sum_in modelled as the adder -> after enter acc_a=45, acc_b=0; 2 edges after add, acc_b=62, acc_a=0, cin=0.
- Keys 9,enter,3,store -> reg_addr=3, reg_wdata=9, reg_we high exactly 1 cycle; then keys clear,3,load with rd_data=9 -> acc_b=9 three edges after load.
- Key 8 strobed while in EXEC -> ignored; acc_b equals the add result only.
- With CALC_ERR_EN: keys 2,6,0 -> acc_b=(260 mod 256)=4, err=1; then store with acc_b=20, NREG=16 -> no reg_we, err stays 1; clear -> err=0.
- Reset asserted during LOAD_DATA -> next cycle all outputs 0, state IDLE, no acc_b update from rd_data.
